// File: rtl/lcd_min_display_pkg.sv
// Shared definitions for the minimum-value LCD display stage: HD44780 command
// bytes, ASCII bases, timer width, FSM state types and the message ROM.
package lcd_min_display_pkg;

    // Wide enough for the longest wait (power-up, 750000 cycles).
    localparam int unsigned CNT_W = 20;
    localparam int unsigned MSG_LEN = 10;

    localparam logic [7:0] CMD_FUNC_SET = 8'h28;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_DDRAM0   = 8'h80;

    localparam logic [7:0] ASCII_DIGIT0  = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_CFG,
        ST_IDLE,
        ST_REFRESH
    } seq_state_e;

    typedef enum logic [2:0] {
        NW_IDLE,
        NW_SETUP,
        NW_EHIGH,
        NW_HOLD,
        NW_WAIT
    } nw_state_e;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_ENTRY;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // "MIN:v AT:p"
    function automatic logic [7:0] msg_char(input logic [3:0] idx,
                                            input logic [2:0] val,
                                            input logic [1:0] pos);
        case (idx)
            4'd0:    return 8'h4D;
            4'd1:    return 8'h49;
            4'd2:    return 8'h4E;
            4'd3:    return 8'h3A;
            4'd4:    return ASCII_DIGIT0 + {5'b0, val};
            4'd5:    return 8'h20;
            4'd6:    return 8'h41;
            4'd7:    return 8'h54;
            4'd8:    return 8'h3A;
            default: return ASCII_UPPER_A + {6'b0, pos};
        endcase
    endfunction

endpackage

// File: rtl/lcd_min_display_nibble_writer.sv
// Writes one 4-bit nibble to the LCD bus with E timing, then waits.
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i             one-cycle request; nibble_i/rs_i/wait_i sampled with it
//   done_o              one-cycle pulse when the post-write wait has elapsed
//   lcd_e_o/rs_o/d_o    registered LCD pins
//
// state    | meaning
// NW_IDLE  | waiting for start
// NW_SETUP | rs/d driven, E low (2 cycles)
// NW_EHIGH | E high for T_EHIGH cycles
// NW_HOLD  | E low, rs/d held 1 cycle
// NW_WAIT  | post-write wait of wait_i cycles
module lcd_nibble_writer
    import lcd_min_display_pkg::*;
#(
    parameter int unsigned T_EHIGH = 12
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       nibble_i,
    input  logic             rs_i,
    input  logic [CNT_W-1:0] wait_i,
    output logic             done_o,
    output logic             lcd_e_o,
    output logic             lcd_rs_o,
    output logic [3:0]       lcd_d_o
);

    nw_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wait_q;
    logic             e_q;
    logic             rs_q;
    logic [3:0]       d_q;
    logic             done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= NW_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                NW_IDLE: begin
                    if (start_i) begin
                        d_q     <= nibble_i;
                        rs_q    <= rs_i;
                        wait_q  <= wait_i;
                        cnt_q   <= CNT_W'(1);
                        state_q <= NW_SETUP;
                    end
                end
                NW_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= CNT_W'(T_EHIGH - 1);
                        state_q <= NW_EHIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                NW_EHIGH: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        state_q <= NW_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                NW_HOLD: begin
                    cnt_q   <= wait_q;
                    state_q <= NW_WAIT;
                end
                NW_WAIT: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= NW_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= NW_IDLE;
            endcase
        end
    end

    assign done_o   = done_q;
    assign lcd_e_o  = e_q;
    assign lcd_rs_o = rs_q;
    assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd_min_display.sv
// HD44780 4-bit display stage for the minimum finder: power-up init, then
// writes "MIN:v AT:p" to line 1 whenever an update is pending.
//   clk, reset          clock, synchronous active-high reset
//   min_val, min_pos    minimum value / index, valid with update
//   update              one-cycle refresh strobe (coalesces while busy)
//   busy                high except when idle with nothing pending
//   lcd_e/rs/rw/d       LCD pins, all registered (rw tied low)
//
// state      | meaning
// ST_PWRUP   | power-up delay, no bus activity
// ST_INIT    | 0x3,0x3,0x3,0x2 reset nibbles
// ST_CFG     | config bytes 0x28,0x06,0x0C,0x01
// ST_IDLE    | waiting for pending update
// ST_REFRESH | DDRAM address 0 then 10 message characters
module lcd_min_display
    import lcd_min_display_pkg::*;
#(
    parameter int unsigned T_PWRUP  = 750000,
    parameter int unsigned T_INIT1  = 205000,
    parameter int unsigned T_INIT2  = 5000,
    parameter int unsigned T_NIBGAP = 50,
    parameter int unsigned T_BYTE   = 2000,
    parameter int unsigned T_CLEAR  = 82000,
    parameter int unsigned T_EHIGH  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] min_val,
    input  logic [1:0] min_pos,
    input  logic       update,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_d
);

    localparam logic [CNT_W-1:0] W_INIT1  = CNT_W'(T_INIT1);
    localparam logic [CNT_W-1:0] W_INIT2  = CNT_W'(T_INIT2);
    localparam logic [CNT_W-1:0] W_NIBGAP = CNT_W'(T_NIBGAP);
    localparam logic [CNT_W-1:0] W_BYTE   = CNT_W'(T_BYTE);
    localparam logic [CNT_W-1:0] W_CLEAR  = CNT_W'(T_CLEAR);

    seq_state_e       state_q;
    logic [3:0]       idx_q;
    logic             lo_q;
    logic             issued_q;
    logic             pending_q;
    logic [CNT_W-1:0] pwr_cnt_q;
    logic [2:0]       val_q;
    logic [1:0]       pos_q;
    logic             start_q;
    logic [3:0]       nib_q;
    logic             rs_q;
    logic [CNT_W-1:0] wait_q;

    logic             nw_done;
    logic [7:0]       cur_byte;
    logic             cur_rs;
    logic             last_byte;

    // Byte currently being sent in ST_CFG / ST_REFRESH; refresh index 0 is the
    // DDRAM address command, 1..10 are message characters.
    always_comb begin
        cur_byte = CMD_DDRAM0;
        cur_rs   = 1'b0;
        if (state_q == ST_CFG) begin
            cur_byte = cfg_byte(idx_q[1:0]);
        end else if (idx_q != 4'd0) begin
            cur_byte = msg_char(idx_q - 4'd1, val_q, pos_q);
            cur_rs   = 1'b1;
        end
    end

    assign last_byte = (state_q == ST_CFG) ? (idx_q == 4'd3) : (idx_q == 4'(MSG_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_PWRUP;
            idx_q     <= '0;
            lo_q      <= 1'b0;
            issued_q  <= 1'b0;
            pending_q <= 1'b1;
            pwr_cnt_q <= CNT_W'(T_PWRUP - 1);
            val_q     <= '0;
            pos_q     <= '0;
            start_q   <= 1'b0;
            nib_q     <= '0;
            rs_q      <= 1'b0;
            wait_q    <= '0;
        end else begin
            start_q <= 1'b0;
            if (update && state_q != ST_IDLE) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_PWRUP: begin
                    if (pwr_cnt_q == '0) begin
                        state_q  <= ST_INIT;
                        idx_q    <= '0;
                        issued_q <= 1'b0;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q - 1'b1;
                    end
                end
                ST_INIT: begin
                    if (!issued_q) begin
                        start_q  <= 1'b1;
                        issued_q <= 1'b1;
                        rs_q     <= 1'b0;
                        nib_q    <= (idx_q == 4'd3) ? 4'h2 : 4'h3;
                        case (idx_q)
                            4'd0:    wait_q <= W_INIT1;
                            4'd1:    wait_q <= W_INIT2;
                            default: wait_q <= W_BYTE;
                        endcase
                    end else if (nw_done) begin
                        issued_q <= 1'b0;
                        if (idx_q == 4'd3) begin
                            state_q <= ST_CFG;
                            idx_q   <= '0;
                            lo_q    <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                ST_CFG, ST_REFRESH: begin
                    if (!issued_q) begin
                        start_q  <= 1'b1;
                        issued_q <= 1'b1;
                        rs_q     <= cur_rs;
                        nib_q    <= lo_q ? cur_byte[3:0] : cur_byte[7:4];
                        if (!lo_q) begin
                            wait_q <= W_NIBGAP;
                        end else if (state_q == ST_CFG && cur_byte == CMD_CLEAR) begin
                            wait_q <= W_CLEAR;
                        end else begin
                            wait_q <= W_BYTE;
                        end
                    end else if (nw_done) begin
                        issued_q <= 1'b0;
                        lo_q     <= !lo_q;
                        if (lo_q) begin
                            if (last_byte) begin
                                state_q <= ST_IDLE;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    // Inputs are sampled once per refresh so the line never
                    // mixes characters from two different updates.
                    if (pending_q || update) begin
                        val_q     <= min_val;
                        pos_q     <= min_pos;
                        pending_q <= 1'b0;
                        state_q   <= ST_REFRESH;
                        idx_q     <= '0;
                        lo_q      <= 1'b0;
                        issued_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    lcd_nibble_writer #(
        .T_EHIGH (T_EHIGH)
    ) u_nibble_writer (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start_q),
        .nibble_i (nib_q),
        .rs_i     (rs_q),
        .wait_i   (wait_q),
        .done_o   (nw_done),
        .lcd_e_o  (lcd_e),
        .lcd_rs_o (lcd_rs),
        .lcd_d_o  (lcd_d)
    );

    assign busy   = !(state_q == ST_IDLE && !pending_q);
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_min_display.sv
module tb_lcd_min_display;

    localparam int unsigned P_PWRUP  = 100;
    localparam int unsigned P_INIT1  = 40;
    localparam int unsigned P_INIT2  = 20;
    localparam int unsigned P_CLEAR  = 30;
    localparam int unsigned P_BYTE   = 10;
    localparam int unsigned P_NIBGAP = 4;
    localparam int unsigned P_EHIGH  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] min_val = '0;
    logic [1:0] min_pos = '0;
    logic       update = 1'b0;
    logic       busy, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_d;

    always #5 clk = ~clk;

    lcd_min_display #(
        .T_PWRUP  (P_PWRUP),
        .T_INIT1  (P_INIT1),
        .T_INIT2  (P_INIT2),
        .T_NIBGAP (P_NIBGAP),
        .T_BYTE   (P_BYTE),
        .T_CLEAR  (P_CLEAR),
        .T_EHIGH  (P_EHIGH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .min_val (min_val),
        .min_pos (min_pos),
        .update  (update),
        .busy    (busy),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_d   (lcd_d)
    );

    int checks = 0;
    int failures = 0;

    logic [4:0] cap_q[$];
    logic [4:0] exp_q[$];

    typedef struct {
        logic [2:0]  val;
        logic [1:0]  pos;
        logic [79:0] msg;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Bus monitor: E pulse width, setup/hold of rs/d, nibble capture on falling E.
    logic       prev_e = 1'b0;
    int         hi_len = 0;
    int         stable = 0;
    logic [4:0] hi_word = '0;
    logic [4:0] last_word = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_e    = 1'b0;
            hi_len    = 0;
            stable    = 1;
            last_word = {lcd_rs, lcd_d};
        end else begin
            if ({lcd_rs, lcd_d} == last_word) begin
                stable++;
            end else begin
                stable    = 1;
                last_word = {lcd_rs, lcd_d};
            end
            if (lcd_e && !prev_e) begin
                check("e_setup", 32'(stable >= 3), 1);
                hi_len  = 1;
                hi_word = {lcd_rs, lcd_d};
            end else if (lcd_e) begin
                hi_len++;
                check("e_data_stable", 32'({lcd_rs, lcd_d}), 32'(hi_word));
            end else if (prev_e) begin
                check("e_width", hi_len, P_EHIGH);
                check("e_hold", 32'({lcd_rs, lcd_d}), 32'(hi_word));
                cap_q.push_back(hi_word);
            end
            prev_e = lcd_e;
        end
    end

    // Reference: message text straight from the display format.
    function automatic logic [79:0] model_msg(input logic [2:0] v, input logic [1:0] p);
        logic [7:0] dch;
        logic [7:0] pch;
        dch = 8'h30 + {5'b0, v};
        pch = 8'h41 + {6'b0, p};
        return {"MIN:", dch, " AT:", pch};
    endfunction

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_refresh(input logic [79:0] msg);
        push_byte(1'b0, 8'h80);
        for (int i = 0; i < 10; i++) push_byte(1'b1, msg[79-8*i -: 8]);
    endtask

    task automatic compare_stream(input string name);
        int nmis;
        int first;
        nmis  = 0;
        first = -1;
        check({name, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                nmis++;
            end
        end
        if (first >= 0)
            check($sformatf("%s_nib%0d", name, first), 32'(cap_q[first]), 32'(exp_q[first]));
        check({name, "_mismatches"}, nmis, 0);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    task automatic do_update(input logic [2:0] v, input logic [1:0] p);
        @(negedge clk);
        min_val = v;
        min_pos = p;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic [2:0] rv;
        logic [1:0] rp;

        vecs[0] = '{3'd2, 2'd1, "MIN:2 AT:B"};
        vecs[1] = '{3'd0, 2'd0, "MIN:0 AT:A"};
        vecs[2] = '{3'd7, 2'd3, "MIN:7 AT:D"};
        vecs[3] = '{3'd4, 2'd2, "MIN:4 AT:C"};
        vecs[4] = '{3'd5, 2'd3, "MIN:5 AT:D"};

        // Reset and power-up init
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_e", 32'(lcd_e), 0);
        check("rst_rs", 32'(lcd_rs), 0);
        check("rst_rw", 32'(lcd_rw), 0);
        check("rst_d", 32'(lcd_d), 0);
        check("rst_busy", 32'(busy), 1);
        reset = 1'b0;
        n = 0;
        while (!lcd_e && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pwrup_e_low", 32'(n >= int'(P_PWRUP) && n <= int'(P_PWRUP) + 10), 1);
        check("init_busy", 32'(busy), 1);
        wait_idle("init", 3000);
        push_init();
        push_refresh("MIN:0 AT:A");
        compare_stream("init");

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            check($sformatf("vec%0d_pre_idle", i), 32'(busy), 0);
            do_update(vecs[i].val, vecs[i].pos);
            check($sformatf("vec%0d_busy_rise", i), 32'(busy), 1);
            wait_idle($sformatf("vec%0d", i), 3000);
            push_refresh(vecs[i].msg);
            compare_stream($sformatf("vec%0d", i));
        end

        // Random values against the model
        for (int i = 0; i < 6; i++) begin
            rv = 3'($urandom_range(0, 7));
            rp = 2'($urandom_range(0, 3));
            do_update(rv, rp);
            wait_idle($sformatf("rnd%0d", i), 3000);
            push_refresh(model_msg(rv, rp));
            compare_stream($sformatf("rnd%0d", i));
        end

        // Coalesced strobes during a refresh
        do_update(3'd1, 2'd1);
        repeat (50) @(negedge clk);
        check("coal_busy", 32'(busy), 1);
        do_update(3'd3, 2'd2);
        repeat (30) @(negedge clk);
        do_update(3'd4, 2'd0);
        repeat (40) @(negedge clk);
        do_update(3'd5, 2'd3);
        wait_idle("coal", 3000);
        push_refresh(model_msg(3'd1, 2'd1));
        push_refresh(model_msg(3'd5, 2'd3));
        compare_stream("coal");
        repeat (200) @(negedge clk);
        check("coal_stay_idle", 32'(busy), 0);
        check("coal_no_extra", cap_q.size(), 0);

        // Reset mid-byte while E is high
        do_update(3'd6, 2'd2);
        rises = 0;
        n = 0;
        while (rises < 2 && n < 500) begin
            @(negedge clk);
            n++;
            if (lcd_e && !prev_e) rises++;
        end
        check("midrst_found_e", 32'(lcd_e), 1);
        reset  = 1'b1;
        update = 1'b1;
        @(negedge clk);
        check("midrst_e_low", 32'(lcd_e), 0);
        check("midrst_busy", 32'(busy), 1);
        @(negedge clk);
        update = 1'b0;
        reset  = 1'b0;
        cap_q.delete();
        exp_q.delete();
        wait_idle("midrst", 3000);
        push_init();
        push_refresh(model_msg(3'd6, 2'd2));
        compare_stream("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
